// File: rtl/axis_uart_tx_pkg.sv
// Shared helpers for the stream-to-UART transmitter and its baud counter.
package axis_uart_tx_pkg;

    // Counter width for a modulus n; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period divider: counts 0..CLOCK_DIV-1 while enabled, held at 0 otherwise.
module uart_baud_counter
    import axis_uart_tx_pkg::*;
#(
    parameter int unsigned CLOCK_DIV = 16
) (
    input  logic clock,
    input  logic resetn,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = cnt_width(CLOCK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLOCK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (!enable || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Final cycle of the current bit period.
    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/axis_uart_tx.sv
// Serialises valid/ready stream words onto a UART line (start, LSB-first data, stop bits).
module axis_uart_tx
    import axis_uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLOCK_DIV  = 16,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] idata,
    input  logic                  ivalid,
    output logic                  iready,
    output logic                  txd,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   shift, shift_next;
    logic [BW-1:0]           bitcnt, bitcnt_next;
    logic                    txd_next, busy_next;
    logic                    baud_en, tick, xfer;

    assign baud_en = (state != IDLE);

    uart_baud_counter #(
        .CLOCK_DIV (CLOCK_DIV)
    ) u_baud (
        .clock  (clock),
        .resetn (resetn),
        .enable (baud_en),
        .tick   (tick)
    );

    // Ready in idle, or in the very last cycle of the final stop bit so frames abut.
    assign iready = (state == IDLE) || (state == STOP && bitcnt == LAST_STOP && tick);
    assign xfer   = ivalid && iready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            shift  <= '0;
            bitcnt <= '0;
            txd    <= 1'b1;
            busy   <= 1'b0;
        end else begin
            state  <= state_next;
            shift  <= shift_next;
            bitcnt <= bitcnt_next;
            txd    <= txd_next;
            busy   <= busy_next;
        end
    end

    // txd_next is derived from the next state so the line flop changes with the state.
    always_comb begin
        state_next  = state;
        shift_next  = shift;
        bitcnt_next = bitcnt;
        txd_next    = txd;
        busy_next   = busy;
        case (state)
            IDLE: begin
                if (xfer) begin
                    state_next  = START;
                    shift_next  = idata;
                    bitcnt_next = '0;
                    txd_next    = 1'b0;
                    busy_next   = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_next  = DATA;
                    bitcnt_next = '0;
                    txd_next    = shift[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bitcnt == LAST_BIT) begin
                        state_next  = STOP;
                        bitcnt_next = '0;
                        txd_next    = 1'b1;
                    end else begin
                        shift_next  = shift >> 1;
                        bitcnt_next = bitcnt + BW'(1);
                        txd_next    = shift[1];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (bitcnt == LAST_STOP) begin
                        bitcnt_next = '0;
                        if (xfer) begin
                            state_next = START;
                            shift_next = idata;
                            txd_next   = 1'b0;
                        end else begin
                            state_next = IDLE;
                            txd_next   = 1'b1;
                            busy_next  = 1'b0;
                        end
                    end else begin
                        bitcnt_next = bitcnt + BW'(1);
                    end
                end
            end
        endcase
    end

endmodule
